alu_op_sequencer: RTL and testbench

- Command-side front end for the team's registered ALU (16-bit default, 3-bit opcode, one-cycle registered result/carryout/overflow/zero).
- Accepts operation requests over a valid/ready command port and drives the ALU operand/opcode inputs.
- Captures the ALU's registered outputs on the correct cycle and returns them over a valid/ready response port.
- Keeps sticky carry/overflow status and a completed-operation counter. Sits between the core/control logic and the ALU at the datapath top level.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_op_sequencer.sv | 90 +++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, response flag bit positions and
// the sequencer FSM state encoding.
package alu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADDU = 3'd0;
    localparam logic [OPW-1:0] OP_ADD  = 3'd1;
    localparam logic [OPW-1:0] OP_SUBU = 3'd2;
    localparam logic [OPW-1:0] OP_SUB  = 3'd3;
    localparam logic [OPW-1:0] OP_AND  = 3'd4;
    localparam logic [OPW-1:0] OP_OR   = 3'd5;
    localparam logic [OPW-1:0] OP_XOR  = 3'd6;
    localparam logic [OPW-1:0] OP_SHR1 = 3'd7;

    // Bit positions inside rsp_flags = {carryout, overflow, zero}
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 1;
    localparam int FLG_ZERO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between the core side (master) and the
// ALU op sequencer (slave).
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int NUMBITS = 16
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [NUMBITS-1:0] cmd_a;
    logic [NUMBITS-1:0] cmd_b;
    logic [OPW-1:0]     cmd_op;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [NUMBITS-1:0] rsp_result;
    logic [2:0]         rsp_flags;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Front end for the registered ALU: accepts one command at a time, drives the
// ALU operand/opcode registers, captures the ALU's registered outputs two
// edges after accept and holds them on the response port until consumed.
// Also keeps sticky carry/overflow and a wrapping completed-op counter.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int NUMBITS  = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus,
    output logic [NUMBITS-1:0]  alu_a,
    output logic [NUMBITS-1:0]  alu_b,
    output logic [OPW-1:0]      alu_opcode,
    input  logic [NUMBITS-1:0]  alu_result,
    input  logic                alu_carryout,
    input  logic                alu_overflow,
    input  logic                alu_zero,
    input  logic                clr_sticky,
    output logic                sticky_carry,
    output logic                sticky_ovf,
    output logic [CNT_BITS-1:0] op_count
);

    seq_state_t         state;
    logic               rsp_valid;
    logic [NUMBITS-1:0] rsp_result;
    logic [2:0]         rsp_flags;
    logic               capture;

    // Only IDLE takes commands; decoded straight from the state register
    assign bus.cmd_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_flags  = rsp_flags;

    assign capture = (state == ST_CAPTURE);

    // Sequencer FSM with all datapath/status outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
            op_count     <= '0;
        end else begin
            // Clear first, then OR in this edge's capture so a coincident set wins
            sticky_carry <= (sticky_carry & ~clr_sticky) | (capture & alu_carryout);
            sticky_ovf   <= (sticky_ovf   & ~clr_sticky) | (capture & alu_overflow);

            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_a      <= bus.cmd_a;
                        alu_b      <= bus.cmd_b;
                        alu_opcode <= bus.cmd_op;
                        state      <= ST_ISSUE;
                    end
                end
                // Operands are stable this cycle; the ALU registers at the closing edge
                ST_ISSUE: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    rsp_result           <= alu_result;
                    rsp_flags[FLG_CARRY] <= alu_carryout;
                    rsp_flags[FLG_OVF]   <= alu_overflow;
                    rsp_flags[FLG_ZERO]  <= alu_zero;
                    rsp_valid            <= 1'b1;
                    op_count             <= op_count + 1'b1;
                    state                <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small registered ALU model
// attached to the ALU-side ports. CNT_BITS is 4 so counter wrap is reachable.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int NB = 16;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] alu_a, alu_b, alu_result;
    logic [2:0]    alu_opcode;
    logic          alu_carryout, alu_overflow, alu_zero;
    logic          clr_sticky;
    logic          sticky_carry, sticky_ovf;
    logic [CB-1:0] op_count;

    int n_pass = 0;
    int n_chk  = 0;

    alu_op_sequencer_if #(.NUMBITS(NB)) bus ();

    alu_op_sequencer #(.NUMBITS(NB), .CNT_BITS(CB)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .clr_sticky   (clr_sticky),
        .sticky_carry (sticky_carry),
        .sticky_ovf   (sticky_ovf),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    // Registered ALU model: carry only for ADDU/SUBU, overflow only for ADD/SUB
    logic [NB:0]   m_sum;
    logic [NB-1:0] m_res;
    logic          m_c, m_v;
    always_comb begin
        m_sum = '0;
        m_res = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_opcode)
            OP_ADDU: begin m_sum = {1'b0, alu_a} + {1'b0, alu_b}; m_res = m_sum[NB-1:0]; m_c = m_sum[NB]; end
            OP_ADD:  begin m_res = alu_a + alu_b; m_v = (alu_a[NB-1] == alu_b[NB-1]) && (m_res[NB-1] != alu_a[NB-1]); end
            OP_SUBU: begin m_res = alu_a - alu_b; m_c = (alu_a < alu_b); end
            OP_SUB:  begin m_res = alu_a - alu_b; m_v = (alu_a[NB-1] != alu_b[NB-1]) && (m_res[NB-1] != alu_a[NB-1]); end
            OP_AND:  m_res = alu_a & alu_b;
            OP_OR:   m_res = alu_a | alu_b;
            OP_XOR:  m_res = alu_a ^ alu_b;
            default: m_res = alu_a >> 1;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            alu_result   <= '0;
            alu_carryout <= 1'b0;
            alu_overflow <= 1'b0;
            alu_zero     <= 1'b0;
        end else begin
            alu_result   <= m_res;
            alu_carryout <= m_c;
            alu_overflow <= m_v;
            alu_zero     <= (m_res == '0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge with the FSM in IDLE; returns just after the capture
    // edge (E0+2) with the response checked.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic clr_cap, input logic [15:0] exp_res, input logic [2:0] exp_flg);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        @(negedge clk);                      // after accept edge E0
        bus.cmd_valid = 1'b0;
        chk("issue_ready",  32'(bus.cmd_ready), 32'd0);
        chk("issue_alu_a",  32'(alu_a), 32'(a));
        chk("issue_alu_op", 32'(alu_opcode), 32'(op));
        chk("issue_vld0",   32'(bus.rsp_valid), 32'd0);
        @(negedge clk);                      // after E0+1, in CAPTURE
        chk("cap_vld0",     32'(bus.rsp_valid), 32'd0);
        clr_sticky = clr_cap;
        @(negedge clk);                      // after E0+2
        clr_sticky = 1'b0;
        chk("rsp_vld",      32'(bus.rsp_valid), 32'd1);
        chk("rsp_result",   32'(bus.rsp_result), 32'(exp_res));
        chk("rsp_flags",    32'(bus.rsp_flags), 32'(exp_flg));
    endtask

    initial begin
        logic seen;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b1;
        clr_sticky    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready",  32'(bus.cmd_ready), 32'd1);
        chk("rst_vld",    32'(bus.rsp_valid), 32'd0);
        chk("rst_res",    32'(bus.rsp_result), 32'd0);
        chk("rst_flags",  32'(bus.rsp_flags), 32'd0);
        chk("rst_alu_a",  32'(alu_a), 32'd0);
        chk("rst_alu_b",  32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        chk("rst_sticky", 32'({sticky_carry, sticky_ovf}), 32'd0);
        chk("rst_cnt",    32'(op_count), 32'd0);

        // ADDU wraps to zero: carry + zero
        issue(16'hFFFF, 16'h0001, OP_ADDU, 1'b0, 16'h0000, 3'b101);
        chk("addu_cnt",  32'(op_count), 32'd1);
        chk("addu_stc",  32'(sticky_carry), 32'd1);
        @(negedge clk);
        chk("addu_idle", 32'(bus.cmd_ready), 32'd1);
        chk("addu_vlde", 32'(bus.rsp_valid), 32'd0);

        // Signed overflow, then sticky_ovf survives a clean AND
        issue(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 3'b010);
        chk("add_sto", 32'(sticky_ovf), 32'd1);
        @(negedge clk);
        issue(16'h00F0, 16'h0F0F, OP_AND, 1'b0, 16'h0000, 3'b001);
        chk("and_sto", 32'(sticky_ovf), 32'd1);
        chk("and_cnt", 32'(op_count), 32'd3);
        @(negedge clk);

        // Backpressure: response held, no accept while a command waits
        bus.rsp_ready = 1'b0;
        issue(16'h1234, 16'h00FF, OP_XOR, 1'b0, 16'h12CB, 3'b000);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 16'h0F00;
        bus.cmd_b     = 16'h00F0;
        bus.cmd_op    = OP_OR;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld",   32'(bus.rsp_valid), 32'd1);
            chk("bp_res",   32'(bus.rsp_result), 32'h12CB);
            chk("bp_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_alu_a", 32'(alu_a), 32'h1234);
        end
        chk("bp_cnt", 32'(op_count), 32'd4);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle",  32'(bus.cmd_ready), 32'd1);
        chk("bp_vlde",  32'(bus.rsp_valid), 32'd0);
        issue(16'h0F00, 16'h00F0, OP_OR, 1'b0, 16'h0FF0, 3'b000);
        chk("or_cnt", 32'(op_count), 32'd5);
        @(negedge clk);

        // Sticky clear alone, then clear coinciding with a carry capture
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("clr_both", 32'({sticky_carry, sticky_ovf}), 32'd0);
        issue(16'h0000, 16'h0001, OP_SUBU, 1'b1, 16'hFFFF, 3'b100);
        chk("clrset_c", 32'(sticky_carry), 32'd1);
        chk("clrset_v", 32'(sticky_ovf), 32'd0);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("clr_late", 32'(sticky_carry), 32'd0);

        // Reset during ISSUE drops the command
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 16'h0003;
        bus.cmd_b     = 16'h0004;
        bus.cmd_op    = OP_ADDU;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("mr_issue_a", 32'(alu_a), 32'h0003);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_vld",   32'(bus.rsp_valid), 32'd0);
        chk("mr_cnt",   32'(op_count), 32'd0);
        chk("mr_alu",   32'({alu_a, alu_b}), 32'd0);
        chk("mr_ready", 32'(bus.cmd_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("mr_norsp", 32'(seen), 32'd0);

        // 16 back-to-back XORs wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            issue(16'h5A5A, 16'(i), OP_XOR, 1'b0, 16'h5A5A ^ 16'(i), 3'b000);
            if (i == 14) chk("wrap_cnt15", 32'(op_count), 32'd15);
            @(negedge clk);
        end
        chk("wrap_cnt0", 32'(op_count), 32'd0);

        // SHR1 drops the low bit, no carry reported
        issue(16'h8001, 16'h0000, OP_SHR1, 1'b0, 16'h4000, 3'b000);
        chk("shr_cnt", 32'(op_count), 32'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
